servant_uart_mon: RTL
=====================

# servant_uart_mon

Parametrised UART receive monitor for the servant simulation environment. It samples the SoC serial output `q`, decodes frames with configurable data length, stop bits and optional parity, and buffers received characters in a FIFO drained with a valid/ready handshake. It also reports framing, parity and overflow errors. It replaces the fixed 8N1, print-only decoder in `servant_tb`, and it is synthesizable so it can also run on board-level test harnesses.

## Interface
Parameters:
- `CLKS_PER_BIT`, 278: `wb_clk` cycles per UART bit, ≥4 (278 = 16 MHz / 57600).
- `DATA_BITS`, 8: data bits per frame, 5–8.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `FIFO_DEPTH`, 16: character FIFO entries, power of two, ≥2.
- `ERR_CNT_W`, 8: width of the error counters, which saturate.

Ports:
- `wb_clk` in 1: clock.
- `wb_rst_n` in 1: asynchronous active-low reset.
- `q` in 1: serial line, asynchronous, idle high.
- `rx_data` out DATA_BITS: FIFO head character, LSB first on the line.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts `rx_data` when `rx_valid & rx_ready`.
- `busy` out 1: receiver not in IDLE.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Tied 0 without `UART_MON_PARITY_EN`.
- `overflow` out 1: sticky. Set when a good character is dropped because the FIFO is full.
- `frame_err_cnt` out ERR_CNT_W: saturating count of framing errors.
- `char_cnt` out 16: wrapping count of characters accepted into the FIFO.

## Operation
- `q` passes through a 2-flop synchronizer to give `q_s`. Reset value is 1.
- The receiver FSM has states IDLE, START, DATA, PARITY, STOP. A down-counter `tick` provides bit timing.
- IDLE: when `q_s` = 0, go to START and load `tick` = (CLKS_PER_BIT-1)/2.
- START: when `tick` = 0, sample `q_s`.
  - 1: false start, return to IDLE with no error.
  - 0: go to DATA and load `tick` = CLKS_PER_BIT-1.
- DATA: sample at each `tick` = 0 and shift in LSB first. After DATA_BITS samples, go to PARITY if enabled, otherwise STOP.
- PARITY: one sample, compared against the configured parity.
- STOP: STOP_BITS samples.
  - Any stop sample of 0: pulse `frame_err`, increment `frame_err_cnt` (saturating), discard the character.
  - Otherwise, if parity failed: pulse `parity_err` and discard.
  - Otherwise: push the character.
  - In every case, return to IDLE immediately after the last stop sample, so a back-to-back start edge is detected.
- Push when the FIFO is full: the character is dropped, `overflow` is set and stays set until reset, and `char_cnt` does not increment.
- FIFO: a pop (`rx_valid & rx_ready`) and a push in the same cycle are both performed, and occupancy is unchanged. This also holds when the FIFO is full.
- Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. Full means the indices are equal and the wrap bits differ.
- `rx_data` is registered from the head entry and is stable while `rx_valid` is high and no pop occurs.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty.
  - `rx_valid` = 0, `rx_data` = 0, `busy` = 0.
  - `frame_err` = 0, `parity_err` = 0, `overflow` = 0.
  - All counters = 0.
  - Synchronizer flops = 1.
- Start detection: the falling edge of `q` reaches `q_s` after 2 cycles. `busy` rises the cycle after `q_s` is first seen low.
- Sample points:
  - Start bit: (CLKS_PER_BIT-1)/2 cycles after the START entry.
  - Each later bit: CLKS_PER_BIT cycles after the previous sample.
- Push happens on the cycle of the final stop sample. `rx_valid` is high on the following cycle. `char_cnt` updates on that same following cycle.
- `frame_err` and `parity_err` are high for exactly one cycle, the cycle after the final stop sample.
- If `wb_rst_n` asserts mid-frame, everything clears asynchronously. After release, the receiver waits in IDLE for a fresh falling edge; a line still low after release starts a frame.
- Throughput: with an empty FIFO, one character per frame time, no gaps needed.

## Configuration
- `UART_MON_PARITY_EN` defined:
  - The PARITY state is present.
  - Input `parity_odd` (1 bit) is added: 0 = even parity, 1 = odd parity.
  - `parity_err` is active as described above.
- `UART_MON_PARITY_EN` undefined:
  - No PARITY state and no `parity_odd` port.
  - Frames are DATA_BITS + STOP_BITS after the start bit.
  - `parity_err` is constant 0.

## Test plan
Use CLKS_PER_BIT = 8 and FIFO_DEPTH = 4 unless stated otherwise.
- Reset release, then an 8N1 frame with 0x48 and `rx_ready` = 1 → `rx_data` = 0x48 with `rx_valid` high for 1 cycle, `char_cnt` = 1, no error pulses.
- Six back-to-back frames "Hello!" with `rx_ready` = 0 → first 4 characters buffered, `overflow` = 1, `char_cnt` = 4. Then `rx_ready` = 1 drains 'H', 'e', 'l', 'l' in order.
- Stop bit forced low on a 0x55 frame → `frame_err` 1-cycle pulse, `frame_err_cnt` = 1, FIFO stays empty. A following good 0x0A frame is received correctly.
- Low glitch of 2 cycles on idle `q` → false start, `busy` returns to 0, no push, no error.
- With `UART_MON_PARITY_EN` and `parity_odd` = 0: frame 0x07 with parity bit 0 → `parity_err` pulse, no push. The same frame with parity bit 1 → accepted.
- `wb_rst_n` pulsed low during the DATA bits of a frame → all outputs at reset values immediately. The next complete 0x31 frame is received correctly.

Source files
------------

// File: rtl/servant_uart_mon.sv
// servant_uart_mon: UART receive monitor with character FIFO and error reporting.
// Optional parity checking is enabled by defining UART_MON_PARITY_EN.
module servant_uart_mon #(
  parameter int CLKS_PER_BIT = 278,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 q,
`ifdef UART_MON_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic [15:0]          char_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_MON_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e state_q, state_d;
  logic s1_q, s2_q, q_s;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic perr_q, perr_d, sbad_q, sbad_d, ferr_q, ferr_d, pe_q, pe_d, ovf_q, ovf_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [ERR_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [15:0] ccnt_q, ccnt_d;
  logic tz, push, pop, full, empty, acc;

  assign q_s = s2_q;

  always_comb begin
    tz = tick_q == '0;
    state_d = state_q;
    tick_d = tz ? TICK_BIT : tick_q - TW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    perr_d = perr_q;
    sbad_d = sbad_q;
    ferr_d = 1'b0;
    pe_d = 1'b0;
    push = 1'b0;
    case (state_q)
      IDLE: if (!q_s) begin
        state_d = START;
        tick_d = TICK_HALF;
        bit_d = '0;
        perr_d = 1'b0;
        sbad_d = 1'b0;
      end
      START: if (tz) state_d = q_s ? IDLE : DATA;
      DATA: if (tz) begin
        shift_d = {q_s, shift_q[DATA_BITS-1:1]};
        bit_d = (bit_q == 3'(DATA_BITS - 1)) ? 3'd0 : bit_q + 3'd1;
`ifdef UART_MON_PARITY_EN
        if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_MON_PARITY_EN
      PARITY: if (tz) begin
        perr_d = ^shift_q ^ q_s ^ parity_odd;
        state_d = STOP;
      end
`endif
      STOP: if (tz) begin
        bit_d = bit_q + 3'd1;
        sbad_d = sbad_q | ~q_s;
        // leave right after the last stop sample so a back-to-back start is caught
        if (bit_q == 3'(STOP_BITS - 1)) begin
          state_d = IDLE;
          ferr_d = sbad_d;
          pe_d = ~sbad_d & perr_q;
          push = ~sbad_d & ~perr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop = ~empty & rx_ready;
    acc = push & (~full | pop);
    wp_d = wp_q + (AW+1)'(acc);
    rp_d = rp_q + (AW+1)'(pop);
    ovf_d = ovf_q | (push & ~acc);
    ccnt_d = ccnt_q + 16'(acc);
    fcnt_d = fcnt_q + ERR_CNT_W'(ferr_d && fcnt_q != '1);
    // a character written into the slot becoming head bypasses the array
    rx_data_d = (acc && wp_q[AW-1:0] == rp_d[AW-1:0]) ? shift_q : mem_q[rp_d[AW-1:0]];
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      sbad_q <= 1'b0;
      ferr_q <= 1'b0;
      pe_q <= 1'b0;
      ovf_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      fcnt_q <= '0;
      ccnt_q <= '0;
      rx_data_q <= '0;
    end else begin
      s1_q <= q;
      s2_q <= s1_q;
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      sbad_q <= sbad_d;
      ferr_q <= ferr_d;
      pe_q <= pe_d;
      ovf_q <= ovf_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      fcnt_q <= fcnt_d;
      ccnt_q <= ccnt_d;
      rx_data_q <= rx_data_d;
    end
  end

  always_ff @(posedge wb_clk) if (acc) mem_q[wp_q[AW-1:0]] <= shift_q;

  assign rx_data = rx_data_q;
  assign rx_valid = ~empty;
  assign busy = state_q != IDLE;
  assign frame_err = ferr_q;
`ifdef UART_MON_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
  assign overflow = ovf_q;
  assign frame_err_cnt = fcnt_q;
  assign char_cnt = ccnt_q;
endmodule
